pipe_hazard_ctrl: RTL
=====================

// Module: pipe_hazard_ctrl
// PURPOSE
// Central stall/flush/forwarding controller for the 5-stage RV32I pipeline; replaces hardwired stall/flush=0 and standalone load-use detector.
// Keeps a shadow scoreboard (valid, rd, rs1/rs2, RegWrite, MemRead) for EX/MEM/WB. Drives PC/pipeline-register enables, bubbles, flushes, EX/ID forward selects.
// Adds branch-redirect flush, multi-cycle EX hold (ex_busy), saturating perf counters.
// PARAMETERS
// REG_AW      5   register address width; x0 (all-zero address) never hazards/forwards
// RF_BYPASS   1   1: regfile write-first, no ID forward; 0: ctrl drives id_fwd_a/b from WB
// CNT_W       32  perf counter width, saturating
// PORTS
// clk             in   1       rising-edge clock
// reset           in   1       synchronous, active-high
// id_valid        in   1       valid instruction in ID
// id_rs1,id_rs2   in   REG_AW  ID source regs
// id_use_rs1/2    in   1       ID instruction reads rs1/rs2
// id_rd           in   REG_AW  ID destination
// id_reg_write    in   1       ID RegWrite
// id_mem_read     in   1       ID MemRead (load)
// ex_redirect     in   1       EX resolved taken branch/JAL/JALR; PC loads target
// ex_busy         in   1       multi-cycle EX op not complete
// pc_en           out  1       PC update enable
// if_id_en        out  1       IF/ID load enable
// if_id_flush     out  1       IF/ID -> invalid/NOP
// id_ex_en        out  1       ID/EX load enable
// id_ex_flush     out  1       ID/EX -> bubble
// ex_mem_flush    out  1       EX/MEM -> bubble
// fwd_a,fwd_b     out  2       EX operand: 00 regfile, 01 EX/MEM ALU_res, 10 WB write data
// id_fwd_a/b      out  1       ID operand from WB (held 0 when RF_BYPASS=1)
// stall_cnt       out  CNT_W   cycles with pc_en=0
// flush_cnt       out  CNT_W   redirect events
// BEHAVIOUR
// - Matches: hazard/forward match requires valid, RegWrite, rd==rs, rd!=0, and the reading stage uses that rs.
// - Priority, all combinational from current state + ID inputs: reset > busy > redirect > load-use.
// - busy (ex_busy & ex_valid): pc_en=if_id_en=id_ex_en=0, ex_mem_flush=1; ex_redirect ignored until busy drops.
// - redirect (ex_redirect & ex_valid & !busy): if_id_flush=id_ex_flush=1, pc_en=if_id_en=1, flush_cnt+1. Load-use suppressed (ID is wrong-path).
// - load-use (ID reads rs matching EX rd, ex_mem_read): pc_en=if_id_en=0, id_ex_flush=1. Exactly 1 bubble; the load forwards from WB next cycle.
// - Otherwise: pc_en=if_id_en=id_ex_en=1, all flushes 0.
// - fwd_x: EX/MEM match -> 01 (priority), else MEM/WB match -> 10, else 00. Load in MEM never forwarded (load-use guarantees 1-cycle gap).
// - id_fwd_x (RF_BYPASS=0 only): ID rs matches WB rd.
// - Shadow update each clk:
//   wb<=mem;
//   mem<=busy?bubble:ex;
//   ex<=busy?ex:(redirect|load-use|!id_valid)?bubble:ID.
// - Reset: all shadow valid=0, counters=0.
//   Reset outputs: pc_en=if_id_en=id_ex_en=1; flushes 0; fwd 00; id_fwd 0; cnt 0.
// - Reset mid-stall/busy: state cleared next edge, no residual bubble.
// - Counters saturate at all-ones, no wrap.
// - stall_cnt increments on every pc_en=0 cycle (busy or load-use).
// STRUCTURE
// - Shared pkg pipe_pkg: fwd_sel_e {FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10}.
// - Shared pkg pipe_pkg: stage_sb_t struct {valid, rd, rs1, rs2, use_rs1, use_rs2, reg_write, mem_read}.
// - Shared pkg pipe_pkg: opcode constants.
// - One sub-module: sat_counter #(CNT_W) (inc, clr), instanced for stall_cnt/flush_cnt.
// TESTING
// 1 ALU chain: addi x1; add x2,x1,x1 -> cycle add in EX: fwd_a=fwd_b=01, no stall.
// 2 Distance-2 dependency: x1 written, gap instr, reader -> fwd_a=10.
// 3 Same rd in MEM+WB: x5 written in both -> fwd_a=01 (MEM priority).
// 4 x0 dest: rd=0 writer then reader -> fwd=00.
// 5 Load-use: lw x3; add x4,x3,x0 -> 1 cycle pc_en=0, id_ex_flush=1; then fwd_a=10; stall_cnt=1.
// 6 Redirect: ex_redirect=1 with ex_valid -> if_id_flush=id_ex_flush=1 same cycle.
//   Next EX/MEM slots invalid. flush_cnt=1.
//   Load-use in ID same cycle -> no stall.
// 7 Busy: ex_busy=1 for 3 cycles -> pc_en=0 and ex_mem_flush=1 for 3 cycles, EX shadow unchanged, stall_cnt+=3.
//   ex_redirect during busy -> ignored.
// 8 Reset asserted mid-load-use -> next cycle outputs equal reset values, counters 0.
//   CNT_W=4: 20 stalls -> stall_cnt=15.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types, opcodes and match helpers for the pipeline hazard controller
package pipe_pkg;

    // Scoreboard register fields are sized for the widest register file we expect to use.
    localparam int SB_AW = 8;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic             valid;
        logic [SB_AW-1:0] rd;
        logic [SB_AW-1:0] rs1;
        logic [SB_AW-1:0] rs2;
        logic             use_rs1;
        logic             use_rs2;
        logic             reg_write;
        logic             mem_read;
    } stage_sb_t;

    localparam stage_sb_t SB_BUBBLE = '0;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    function automatic logic opc_is_load(input logic [6:0] opc);
        return opc == OPC_LOAD;
    endfunction

    // A stage produces register r for a reader only if it really writes a non-x0 register.
    function automatic logic sb_writes(input stage_sb_t s, input logic [SB_AW-1:0] r,
                                       input logic use_r);
        return s.valid && s.reg_write && (s.rd != '0) && (s.rd == r) && use_r;
    endfunction

    // Loads sitting in MEM have no data yet; the load-use bubble lets WB supply them instead.
    function automatic fwd_sel_e pick_fwd(input stage_sb_t mem_s, input stage_sb_t wb_s,
                                          input logic [SB_AW-1:0] r, input logic use_r);
        if (!mem_s.mem_read && sb_writes(mem_s, r, use_r)) begin
            return FWD_MEM;
        end
        if (sb_writes(wb_s, r, use_r)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush/forwarding controller for the 5-stage RV32I pipeline
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_AW    = 5,
    parameter bit RF_BYPASS = 1'b1,
    parameter int CNT_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              ex_redirect,
    input  logic              ex_busy,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              if_id_flush,
    output logic              id_ex_en,
    output logic              id_ex_flush,
    output logic              ex_mem_flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              id_fwd_a,
    output logic              id_fwd_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    stage_sb_t ex_q, mem_q, wb_q;
    stage_sb_t ex_d, mem_d, wb_d;
    stage_sb_t id_sb;

    logic busy;
    logic redirect;
    logic load_use_raw;
    logic load_use;
    logic stall_inc;
    logic flush_inc;

    assign id_sb = '{
        valid:     id_valid,
        rd:        SB_AW'(id_rd),
        rs1:       SB_AW'(id_rs1),
        rs2:       SB_AW'(id_rs2),
        use_rs1:   id_use_rs1,
        use_rs2:   id_use_rs2,
        reg_write: id_reg_write,
        mem_read:  id_mem_read
    };

    assign busy         = ex_busy && ex_q.valid;
    assign redirect     = ex_redirect && ex_q.valid && !busy;
    assign load_use_raw = id_valid && ex_q.mem_read &&
                          (sb_writes(ex_q, id_sb.rs1, id_use_rs1) ||
                           sb_writes(ex_q, id_sb.rs2, id_use_rs2));
    // A redirect squashes ID, so a load-use seen there is on the wrong path.
    assign load_use     = load_use_raw && !busy && !redirect;

    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        if (!reset) begin
            if (busy) begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_en     = 1'b0;
                ex_mem_flush = 1'b1;
            end else if (redirect) begin
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
            end else if (load_use) begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_flush  = 1'b1;
            end
        end
    end

    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (!reset) begin
            fwd_a = pick_fwd(mem_q, wb_q, ex_q.rs1, ex_q.valid && ex_q.use_rs1);
            fwd_b = pick_fwd(mem_q, wb_q, ex_q.rs2, ex_q.valid && ex_q.use_rs2);
        end
    end

    // With a write-first register file the ID read already sees WB, so no ID bypass is needed.
    assign id_fwd_a = !RF_BYPASS && !reset && id_valid && sb_writes(wb_q, id_sb.rs1, id_use_rs1);
    assign id_fwd_b = !RF_BYPASS && !reset && id_valid && sb_writes(wb_q, id_sb.rs2, id_use_rs2);

    always_comb begin
        wb_d  = mem_q;
        mem_d = busy ? SB_BUBBLE : ex_q;
        if (busy) begin
            ex_d = ex_q;
        end else if (redirect || load_use || !id_valid) begin
            ex_d = SB_BUBBLE;
        end else begin
            ex_d = id_sb;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q  <= SB_BUBBLE;
            mem_q <= SB_BUBBLE;
            wb_q  <= SB_BUBBLE;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    assign stall_inc = !reset && !pc_en;
    assign flush_inc = !reset && redirect;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk_i (clk),
        .clr_i (reset),
        .inc_i (stall_inc),
        .cnt_o (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk_i (clk),
        .clr_i (reset),
        .inc_i (flush_inc),
        .cnt_o (flush_cnt)
    );

    logic unused_sb;
    assign unused_sb = ^{mem_q.rs1, mem_q.rs2, mem_q.use_rs1, mem_q.use_rs2,
                         wb_q.rs1, wb_q.rs2, wb_q.use_rs1, wb_q.use_rs2, wb_q.mem_read};

endmodule
